// File: rtl/handshake_sink_fsm.sv
// Sink side of a 4-phase req/ack link: synchronizes req, captures data_in into a FWFT FIFO.
// Optional macro HS_SINK_XFER_COUNT_EN builds a 16-bit wrapping capture counter on xfer_count.
module handshake_sink_fsm #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   xfer_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    WAIT_REQ = 2'b00,
    ACK_HOLD = 2'b01
  } state_e;

  state_e                   state_q, state_d;
  logic                     ack_q, ack_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     req_s;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic                     full, push, pop;

  // req synchronizer; data_in relies on the source holding it stable while req is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // FIFO status comes straight from the registered count
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_REQ;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // next-state: one capture per handshake, never while full
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      WAIT_REQ: begin
        if (req_s && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HOLD;
        end
      end
      ACK_HOLD: begin
        if (req_s) ack_d   = 1'b1;
        else       state_d = WAIT_REQ;
      end
      default: begin
        state_d = WAIT_REQ;
      end
    endcase
  end

  assign ack = ack_q;

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // storage needs no reset: nothing is visible until count is non-zero
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;

`ifdef HS_SINK_XFER_COUNT_EN
  logic [15:0] xfer_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     xfer_q <= '0;
    else if (push) xfer_q <= xfer_q + 16'(1);
  end

  assign xfer_count = xfer_q;
`else
  assign xfer_count = 16'h0000;
`endif

endmodule

// File: tb/tb_handshake_sink_fsm.sv
// Bench for handshake_sink_fsm: vector table, directed corner sequences and a random source
// checked every cycle against a queue-based model of the sink.
module tb_handshake_sink_fsm;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [7:0]  data_in;
  logic        ack;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  fifo_count;
  logic [15:0] xfer_count;

  handshake_sink_fsm #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_count(fifo_count), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [7:0] data;
    logic       rdy;
    logic       e_ack;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl [7];

  // model: req delay line, handshake flag, FIFO queue, capture tally
  bit          sq [SYNC];
  logic [7:0]  mq [$];
  bit          ack_m;
  logic [15:0] xfer_m;

  int          n_cmp = 0;
  int          n_err = 0;
  int          max_cnt;
  logic [7:0]  popped [$];
  logic [7:0]  sent [10];

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) sq[i] = 1'b0;
    mq.delete();
    ack_m  = 1'b0;
    xfer_m = 16'h0;
  endtask

  task automatic model_step();
    bit rs, full, pp, ps;
    rs   = sq[SYNC-1];
    full = (mq.size() == DEPTH);
    pp   = (mq.size() != 0) && out_ready;
    ps   = !ack_m && rs && !full;
    if (pp) void'(mq.pop_front());
    if (ps) begin
      mq.push_back(data_in);
      xfer_m = xfer_m + 16'h1;
    end
    ack_m = ack_m ? rs : ps;
    for (int i = SYNC - 1; i > 0; i--) sq[i] = sq[i-1];
    sq[0] = req;
  endtask

  function automatic logic [28:0] exp_vec();
    logic [15:0] x;
    logic [7:0]  h;
`ifdef HS_SINK_XFER_COUNT_EN
    x = xfer_m;
`else
    x = 16'h0;
`endif
    h = (mq.size() != 0) ? mq[0] : 8'h00;
    return {ack_m, (mq.size() != 0), h, 3'(mq.size()), x};
  endfunction

  // one clock: drive at negedge, step model on posedge, compare at next negedge
  task automatic cycle(input logic r, input logic [7:0] d, input logic rdy);
    req = r; data_in = d; out_ready = rdy;
    if (out_valid && rdy) popped.push_back(out_data);
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp("cycle_vs_model", {ack, out_valid, out_data, fifo_count, xfer_count}, exp_vec());
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  endtask

  task automatic raise(input logic [7:0] d, input logic rdy);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, d, rdy);
      if (ack) break;
    end
    cmp("ack_rise_timeout", ack, 1'b1);
  endtask

  task automatic lower(input logic rdy);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 8'h00, rdy);
      if (!ack) break;
    end
    cmp("ack_fall_timeout", ack, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input logic rdy);
    raise(d, rdy);
    lower(rdy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         st;
    int         gap;
    logic       r;
    logic [7:0] d;

    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

    reset = 1'b1; req = 1'b0; data_in = 8'h00; out_ready = 1'b0;
    model_reset();
    max_cnt = 0;
    @(negedge clk); @(negedge clk);
    cmp("reset_state", {ack, out_valid, out_data, fifo_count, xfer_count}, 29'h0);
    reset = 1'b0;

    // single transfer: ack three edges after req rises and three after it falls
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].req, tbl[i].data, tbl[i].rdy);
      cmp($sformatf("tbl_row%0d", i), {ack, out_valid, out_data, fifo_count},
          {tbl[i].e_ack, tbl[i].e_valid, tbl[i].e_data, tbl[i].e_cnt});
    end
`ifdef HS_SINK_XFER_COUNT_EN
    cmp("single_xfer_count", xfer_count, 16'd1);
`else
    cmp("single_xfer_count", xfer_count, 16'd0);
`endif
    cmp("single_popped", popped.size() == 1 ? popped[0] : 8'hFF, 8'hA5);

    // burst into a stalled consumer, then backpressure on the fifth request
    popped.delete();
    for (int b = 1; b <= 4; b++) send(8'(b), 1'b0);
    cmp("burst_full_count", fifo_count, 3'd4);
    cmp("burst_head", out_data, 8'h01);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'h05, 1'b0);
      cmp("full_no_ack", ack, 1'b0);
    end
    cycle(1'b1, 8'h05, 1'b1);
    cmp("pop_while_full_no_push", {ack, fifo_count}, {1'b0, 3'd3});
    raise(8'h05, 1'b0);
    cmp("late_capture_count", fifo_count, 3'd4);
    lower(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    cmp("burst_drained", fifo_count, 3'd0);
    cmp("burst_pop_n", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      cmp($sformatf("burst_order%0d", i), popped[i], 8'(i + 1));

    // pointer wrap with a free-running consumer
    popped.delete();
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sent[i] = 8'($urandom);
      send(sent[i], 1'b1);
    end
    cycle(1'b0, 8'h00, 1'b1);
    cmp("wrap_pop_n", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      cmp($sformatf("wrap_data%0d", i), popped[i], sent[i]);
    cmp("wrap_max_count", max_cnt, 1);

    // capture and pop on the same edge with two entries held
    popped.delete();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    cycle(1'b1, 8'h33, 1'b1);
    cmp("pushpop_state", {ack, fifo_count, out_data}, {1'b1, 3'd2, 8'h22});
    lower(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    cmp("pushpop_pop_n", popped.size(), 3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      cmp($sformatf("pushpop_order%0d", i), popped[i], 8'h11 * 8'(i + 1));

    // reset while holding ack with three entries buffered
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    raise(8'h43, 1'b0);
    cmp("pre_reset_count", fifo_count, 3'd3);
    reset = 1'b1;
    req   = 1'b0;
    #1;
    cmp("async_reset_outputs", {ack, out_valid, out_data, fifo_count, xfer_count}, 29'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);

    // random source and consumer
    st = 0; gap = 0; r = 1'b0; d = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      case (st)
        0: if (gap == 0) begin
             d = 8'($urandom); r = 1'b1; st = 1;
           end else gap--;
        1: if (ack) begin
             r = 1'b0; st = 2;
           end
        default: if (!ack) begin
             gap = $urandom_range(0, 3); st = 0;
           end
      endcase
      cycle(r, d, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
